count_bcd_display: RTL

//  Downstream consumer of the N-bit free-running counter: samples its count on a

---
 rtl/display_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/count_bcd_display.sv | 95 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the BCD 7-segment display path: FSM state
// encoding, blank pattern and the active-low digit-to-segment decoder.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit is blanked.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle for N cycles, then a
// one-cycle LATCH where bcd_valid pulses. State is exported on dbg_state.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int N          = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            value,
  input  logic                    load,
  output logic                    busy,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    bcd_valid,
  output state_t                  dbg_state
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * BCD_DIGITS;

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_bin;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   w_adj;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (load) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CW'(N - 1)) w_state_next = LATCH;
      LATCH:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Add-3 correction is applied before the shift so each nibble stays decimal.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin <= value;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[BW-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign bcd_valid = (r_state == LATCH);
  assign bcd       = r_bcd;
  assign dbg_state = r_state;

endmodule

// File: rtl/count_bcd_display.sv
// Captures a binary count, converts it to BCD and scans it onto an 8-digit
// common-anode 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module count_bcd_display
  import display_pkg::*;
#(
  parameter int N           = 16,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      value,
  input  logic              load,
  output logic              busy,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] anodes,
  output state_t            dbg_state
);

  localparam int BCD_DIGITS = (N * 301) / 1000 + 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (DIGITS < BCD_DIGITS) begin : g_digits_check
    $error("count_bcd_display: DIGITS too small for N-bit value");
  end

  logic [4*BCD_DIGITS-1:0]   w_bcd;
  logic                      w_bcd_valid;
  logic [DIGITS-1:0][3:0]    r_disp;
  logic [DIGITS-1:0][3:0]    w_disp_next;
  logic [DIGITS-1:0]         w_blank;
  logic [RW-1:0]             r_refresh;
  logic [IW-1:0]             r_idx;
  logic [DIGITS-1:0]         r_anodes;
  logic [6:0]                r_segments;
  logic                      w_tick;

  bin2bcd_seq #(
    .N          (N),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .busy      (busy),
    .bcd       (w_bcd),
    .bcd_valid (w_bcd_valid),
    .dbg_state (dbg_state)
  );

  // Digits beyond the converter's reach are held at zero.
  always_comb begin
    w_disp_next = '0;
    for (int i = 0; i < BCD_DIGITS; i++) w_disp_next[i] = w_bcd[4*i +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top down; digit 0 is never blanked so zero shows as '0'.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    w_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (r_disp[i] != 4'd0) seen = 1'b1;
      w_blank[i] = ~seen;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_tick = (r_refresh == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp     <= '0;
      r_refresh  <= '0;
      r_idx      <= '0;
      r_anodes   <= '1;
      r_segments <= SEG_BLANK;
    end else begin
      if (w_bcd_valid) r_disp <= w_disp_next;
      r_refresh <= w_tick ? '0 : r_refresh + RW'(1);
      if (w_tick) r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      r_anodes   <= ~(DIGITS'(1) << r_idx);
      r_segments <= w_blank[r_idx] ? SEG_BLANK : seg_code(r_disp[r_idx]);
    end
  end

  assign anodes   = r_anodes;
  assign segments = r_segments;

endmodule
